// File: rtl/timer_avmm_master.sv
// Avalon-MM master that turns local timer commands into interval-timer register
// sequences and services the timer irq by clearing status and counting timeouts.
module timer_avmm_master #(
  parameter int COUNT_W        = 16,
  parameter bit IRQ_AUTO_CLEAR = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [31:0]        cmd_period,
  input  logic               cmd_continuous,
  input  logic               cmd_irq_en,
  output logic               cmd_done,
  output logic [31:0]        snap_value,
  output logic [COUNT_W-1:0] timeout_count,
  output logic               timeout_tick,
  output logic [2:0]         avm_address,
  output logic               avm_chipselect,
  output logic               avm_write_n,
  output logic [15:0]        avm_writedata,
  input  logic [15:0]        avm_readdata,
  input  logic               irq
);

  typedef enum logic [3:0] {
    IDLE,
    CFG_PL,
    CFG_PH,
    CFG_CTRL,
    STOP_CTRL,
    SNAP_WR,
    SNAP_RDL,
    SNAP_RDH,
    SNAP_CAP,
    CLR_ST,
    DONE
  } state_t;

  localparam logic [1:0] OP_CONFIG   = 2'd0;
  localparam logic [1:0] OP_STOP     = 2'd1;
  localparam logic [1:0] OP_SNAPSHOT = 2'd2;

  state_t      state;
  logic [15:0] period_hi;
  logic        cont_q;
  logic        ito_q;
  logic        irq_req;

  assign irq_req   = IRQ_AUTO_CLEAR && irq;
  assign cmd_ready = (state == IDLE) && !irq_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      cmd_done       <= 1'b0;
      timeout_tick   <= 1'b0;
      snap_value     <= '0;
      timeout_count  <= '0;
      period_hi      <= '0;
      cont_q         <= 1'b0;
      ito_q          <= 1'b0;
    end else begin
      // Bus defaults to idle; each state below only drives the cycle it owns.
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
      avm_address    <= '0;
      avm_writedata  <= '0;
      cmd_done       <= 1'b0;
      timeout_tick   <= 1'b0;

      unique case (state)
        IDLE: begin
          if (irq_req) begin
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            avm_address    <= 3'd0;
            avm_writedata  <= '0;
            state          <= CLR_ST;
          end else if (cmd_valid) begin
            period_hi <= cmd_period[31:16];
            cont_q    <= cmd_continuous;
            ito_q     <= cmd_irq_en;
            unique case (cmd_op)
              OP_CONFIG: begin
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
                avm_address    <= 3'd2;
                avm_writedata  <= cmd_period[15:0];
                state          <= CFG_PL;
              end
              OP_STOP: begin
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
                avm_address    <= 3'd1;
                avm_writedata  <= {12'h000, 2'b10, cmd_continuous, cmd_irq_en};
                state          <= STOP_CTRL;
              end
              OP_SNAPSHOT: begin
                avm_chipselect <= 1'b1;
                avm_write_n    <= 1'b0;
                avm_address    <= 3'd4;
                avm_writedata  <= '0;
                state          <= SNAP_WR;
              end
              default: begin
                cmd_done <= 1'b1;
                state    <= DONE;
              end
            endcase
          end
        end
        CFG_PL: begin
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd3;
          avm_writedata  <= period_hi;
          state          <= CFG_PH;
        end
        CFG_PH: begin
          // Start goes last: each period write force-stops the counter.
          avm_chipselect <= 1'b1;
          avm_write_n    <= 1'b0;
          avm_address    <= 3'd1;
          avm_writedata  <= {12'h000, 2'b01, cont_q, ito_q};
          state          <= CFG_CTRL;
        end
        CFG_CTRL, STOP_CTRL: begin
          cmd_done <= 1'b1;
          state    <= DONE;
        end
        SNAP_WR: begin
          avm_chipselect <= 1'b1;
          avm_address    <= 3'd4;
          state          <= SNAP_RDL;
        end
        SNAP_RDL: begin
          avm_chipselect <= 1'b1;
          avm_address    <= 3'd5;
          state          <= SNAP_RDH;
        end
        SNAP_RDH: begin
          snap_value[15:0] <= avm_readdata;
          state            <= SNAP_CAP;
        end
        SNAP_CAP: begin
          snap_value[31:16] <= avm_readdata;
          cmd_done          <= 1'b1;
          state             <= DONE;
        end
        CLR_ST: begin
          timeout_tick  <= 1'b1;
          timeout_count <= timeout_count + COUNT_W'(1);
          state         <= IDLE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_timer_avmm_master.sv
// Bench for timer_avmm_master: attached interval-timer model, transaction-level
// reference model checked every cycle, directed scenarios and a random phase.
module tb_timer_avmm_master;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'd3;
  logic [31:0]   cmd_period = '0;
  logic          cmd_continuous = 1'b0;
  logic          cmd_irq_en = 1'b0;
  logic          cmd_ready;
  logic          cmd_done;
  logic [31:0]   snap_value;
  logic [CW-1:0] timeout_count;
  logic          timeout_tick;
  logic [2:0]    avm_address;
  logic          avm_chipselect;
  logic          avm_write_n;
  logic [15:0]   avm_writedata;
  logic [15:0]   avm_readdata;
  logic          irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  timer_avmm_master #(.COUNT_W(CW), .IRQ_AUTO_CLEAR(1'b1)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_period(cmd_period), .cmd_continuous(cmd_continuous), .cmd_irq_en(cmd_irq_en),
    .cmd_done(cmd_done), .snap_value(snap_value),
    .timeout_count(timeout_count), .timeout_tick(timeout_tick),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .irq(irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired at t=%0t", name, $time);
  endtask

  // ---------------- interval timer slave model ----------------
  logic [15:0] t_pl, t_ph, t_sl, t_sh, t_rdata;
  logic [31:0] t_cnt;
  logic        t_to, t_run, t_ito, t_cont;
  int unsigned t_rises;
  logic        force_req = 1'b0;
  logic [31:0] force_val = '0;

  assign irq          = t_to & t_ito;
  assign avm_readdata = t_rdata;

  always @(posedge clk) begin : timer_model
    logic [31:0] cnt_n;
    logic        run_n, to_n;
    if (reset) begin
      t_pl <= '0; t_ph <= '0; t_sl <= '0; t_sh <= '0; t_rdata <= '0;
      t_cnt <= '0; t_to <= 1'b0; t_run <= 1'b0; t_ito <= 1'b0; t_cont <= 1'b0;
      t_rises <= 0;
    end else begin
      cnt_n = t_cnt; run_n = t_run; to_n = t_to;
      if (avm_chipselect && avm_write_n) begin
        case (avm_address)
          3'd0: t_rdata <= {14'h0, t_run, t_to};
          3'd1: t_rdata <= {14'h0, t_cont, t_ito};
          3'd2: t_rdata <= t_pl;
          3'd3: t_rdata <= t_ph;
          3'd4: t_rdata <= t_sl;
          3'd5: t_rdata <= t_sh;
          default: t_rdata <= '0;
        endcase
      end
      if (t_run) begin
        if (t_cnt == 0) begin
          to_n  = 1'b1;
          cnt_n = {t_ph, t_pl};
          if (!t_cont) run_n = 1'b0;
        end else begin
          cnt_n = t_cnt - 1;
        end
      end
      if (avm_chipselect && !avm_write_n) begin
        case (avm_address)
          3'd0: to_n = 1'b0;
          3'd1: begin
            t_ito  <= avm_writedata[0];
            t_cont <= avm_writedata[1];
            if (avm_writedata[2]) run_n = 1'b1;
            if (avm_writedata[3]) run_n = 1'b0;
          end
          3'd2: begin t_pl <= avm_writedata; run_n = 1'b0; cnt_n = {t_ph, avm_writedata}; end
          3'd3: begin t_ph <= avm_writedata; run_n = 1'b0; cnt_n = {avm_writedata, t_pl}; end
          3'd4: begin t_sl <= t_cnt[15:0]; t_sh <= t_cnt[31:16]; end
          default: ;
        endcase
      end
      if (force_req) cnt_n = force_val;
      if (to_n && !t_to) t_rises <= t_rises + 1;
      t_cnt <= cnt_n; t_run <= run_n; t_to <= to_n;
    end
  end

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    bit        cs;
    bit        wn;
    bit [2:0]  a;
    bit [15:0] d;
    bit        done;
    bit        then_tick;
    bit        cap_lo;
    bit        cap_hi;
    bit        snap_upd;
    bit        skip_snap;
  } item_t;

  item_t         q[$];
  logic          rst_q = 1'b1;
  bit            pend_tick = 1'b0;
  bit            exp_tick;
  logic [CW-1:0] exp_count = '0;
  logic [31:0]   exp_snap = '0;
  logic [15:0]   cap_lo_v = '0, cap_hi_v = '0;
  int            cyc = 0;
  logic [2:0]    log_a[$];
  logic [15:0]   log_d[$];
  int            log_t[$];

  function automatic item_t bus(input bit cs, input bit wn, input bit [2:0] a, input bit [15:0] d);
    item_t it;
    it.cs = cs; it.wn = wn; it.a = a; it.d = d;
    it.done = 0; it.then_tick = 0; it.cap_lo = 0; it.cap_hi = 0;
    it.snap_upd = 0; it.skip_snap = 0;
    return it;
  endfunction

  task automatic push_cmd(input logic [1:0] op, input logic [31:0] p, input logic c, input logic i);
    item_t it;
    case (op)
      2'd0: begin
        q.push_back(bus(1, 0, 3'd2, p[15:0]));
        q.push_back(bus(1, 0, 3'd3, p[31:16]));
        q.push_back(bus(1, 0, 3'd1, {12'h000, 2'b01, c, i}));
      end
      2'd1: q.push_back(bus(1, 0, 3'd1, {12'h000, 2'b10, c, i}));
      2'd2: begin
        q.push_back(bus(1, 0, 3'd4, 16'h0));
        q.push_back(bus(1, 1, 3'd4, 16'h0));
        it = bus(1, 1, 3'd5, 16'h0); it.cap_lo = 1; q.push_back(it);
        it = bus(0, 1, 3'd0, 16'h0); it.cap_hi = 1; it.skip_snap = 1; q.push_back(it);
      end
      default: ;
    endcase
    it = bus(0, 1, 3'd0, 16'h0);
    it.done = 1;
    it.snap_upd = (op == 2'd2);
    q.push_back(it);
  endtask

  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin : compare
    item_t it;
    bit    idle;
    cyc++;
    if (rst_q) begin
      q.delete(); pend_tick = 0; exp_count = '0; exp_snap = '0;
    end
    idle = (q.size() == 0);
    if (idle) it = bus(0, 1, 3'd0, 16'h0);
    else it = q.pop_front();
    exp_tick  = pend_tick;
    pend_tick = it.then_tick;
    if (exp_tick) exp_count = exp_count + CW'(1);
    if (it.cap_lo) cap_lo_v = avm_readdata;
    if (it.cap_hi) cap_hi_v = avm_readdata;
    if (it.snap_upd) exp_snap = {cap_hi_v, cap_lo_v};

    chk("chipselect", 32'(avm_chipselect), 32'(it.cs));
    chk("write_n", 32'(avm_write_n), 32'(it.wn));
    if (it.cs) chk("address", 32'(avm_address), 32'(it.a));
    if (it.cs && !it.wn) chk("writedata", 32'(avm_writedata), 32'(it.d));
    chk("cmd_done", 32'(cmd_done), 32'(it.done));
    chk("timeout_tick", 32'(timeout_tick), 32'(exp_tick));
    chk("timeout_count", 32'(timeout_count), 32'(exp_count));
    if (!it.skip_snap) chk("snap_value", snap_value, exp_snap);
    chk("cmd_ready", 32'(cmd_ready), 32'(idle && !irq));

    if (avm_chipselect && !avm_write_n) begin
      log_a.push_back(avm_address); log_d.push_back(avm_writedata); log_t.push_back(cyc);
    end

    if (idle && !reset) begin
      if (irq) begin
        it = bus(1, 0, 3'd0, 16'h0);
        it.then_tick = 1;
        q.push_back(it);
      end else if (cmd_valid) begin
        push_cmd(cmd_op, cmd_period, cmd_continuous, cmd_irq_en);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue_cmd(input logic [1:0] op, input logic [31:0] p, input logic c,
                           input logic i, output int lat);
    bit acc = 0;
    lat = -1;
    cmd_op = op; cmd_period = p; cmd_continuous = c; cmd_irq_en = i; cmd_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (cmd_ready) acc = 1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_op = 2'($urandom); cmd_period = $urandom;
    cmd_continuous = 1'($urandom); cmd_irq_en = 1'($urandom);
    if (!acc) begin
      bound_fail("cmd_accept");
      return;
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (cmd_done) begin
        lat = k;
        @(posedge clk); #1;
        return;
      end
      @(posedge clk); #1;
    end
    bound_fail("cmd_done_wait");
  endtask

  task automatic force_counter(input logic [31:0] v);
    force_val = v; force_req = 1'b1;
    @(posedge clk); #1;
    force_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int n;
    int ticks;
    bit found;

    // Reset with a command already pending.
    reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd3;
    repeat (4) begin
      @(negedge clk);
      chk("rst_chipselect", 32'(avm_chipselect), 32'h0);
      chk("rst_write_n", 32'(avm_write_n), 32'h1);
      chk("rst_cmd_done", 32'(cmd_done), 32'h0);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("nop_done_c1", 32'(cmd_done), 32'h1);
    @(posedge clk); #1;

    // CONFIG: three writes on consecutive cycles, start last.
    issue_cmd(2'd0, 32'h0003_0D3F, 1'b1, 1'b1, lat);
    chk("cfg_latency", 32'(lat), 32'd4);
    n = log_a.size();
    chk("cfg_w0_addr", 32'(log_a[n-3]), 32'd2);
    chk("cfg_w0_data", 32'(log_d[n-3]), 32'h0D3F);
    chk("cfg_w1_addr", 32'(log_a[n-2]), 32'd3);
    chk("cfg_w1_data", 32'(log_d[n-2]), 32'h0003);
    chk("cfg_w2_addr", 32'(log_a[n-1]), 32'd1);
    chk("cfg_w2_data", 32'(log_d[n-1]), 32'h0007);
    chk("cfg_consecutive", 32'(log_t[n-1] - log_t[n-3]), 32'd2);
    chk("timer_running", 32'(t_run), 32'h1);

    // STOP with cont=0, ito=1.
    issue_cmd(2'd1, 32'h0, 1'b0, 1'b1, lat);
    chk("stop_latency", 32'(lat), 32'd2);
    n = log_a.size();
    chk("stop_addr", 32'(log_a[n-1]), 32'd1);
    chk("stop_data", 32'(log_d[n-1]), 32'h0009);
    chk("timer_stopped", 32'(t_run), 32'h0);

    // Two snapshots of a held counter.
    force_counter(32'h0001_2345);
    issue_cmd(2'd2, 32'h0, 1'b0, 1'b0, lat);
    chk("snap1_latency", 32'(lat), 32'd5);
    chk("snap1_value", snap_value, 32'h0001_2345);
    force_counter(32'h0000_0010);
    issue_cmd(2'd2, 32'h0, 1'b0, 1'b0, lat);
    chk("snap2_value", snap_value, 32'h0000_0010);

    // Reset at c2 of a SNAPSHOT aborts it.
    cmd_op = 2'd2; cmd_valid = 1'b1;
    @(negedge clk);
    chk("snap_rst_ready", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_chipselect", 32'(avm_chipselect), 32'h0);
    chk("abort_write_n", 32'(avm_write_n), 32'h1);
    chk("abort_snap", snap_value, 32'h0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(cmd_done), 32'h0);
    end
    @(posedge clk); #1;

    // Period 3 continuous: five serviced timeouts wrap a 2-bit count to 1.
    issue_cmd(2'd0, 32'd3, 1'b1, 1'b1, lat);
    ticks = 0; found = 0;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (timeout_tick) ticks++;
      if (ticks == 5) begin
        found = 1;
        chk("count_wrap", 32'(timeout_count), 32'h1);
        chk("one_tick_per_timeout", 32'(t_rises), 32'd5);
      end
      @(posedge clk); #1;
    end
    if (!found) bound_fail("five_ticks");
    issue_cmd(2'd1, 32'h0, 1'b0, 1'b0, lat);
    repeat (4) begin @(posedge clk); #1; end

    // irq rising together with cmd_valid: service first, then accept.
    issue_cmd(2'd0, 32'd10, 1'b1, 1'b1, lat);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (t_run && t_cnt == 0 && !irq) found = 1;
    end
    if (!found) bound_fail("irq_align");
    @(posedge clk); #1;
    cmd_op = 2'd3; cmd_valid = 1'b1;
    @(negedge clk);
    chk("race_irq_high", 32'(irq), 32'h1);
    chk("race_ready_low", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("race_clear_write", {29'h0, avm_chipselect, avm_write_n, 1'b0}, 32'h4);
    chk("race_clear_addr", 32'(avm_address), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("race_ready_after", 32'(cmd_ready), 32'h1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("race_nop_done", 32'(cmd_done), 32'h1);
    @(posedge clk); #1;
    issue_cmd(2'd1, 32'h0, 1'b0, 1'b0, lat);
    repeat (4) begin @(posedge clk); #1; end

    // irq during CONFIG: service waits until after cmd_done.
    issue_cmd(2'd0, 32'd8, 1'b0, 1'b1, lat);
    found = 0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      if (t_run && t_cnt == 1) found = 1;
    end
    if (!found) bound_fail("cfg_irq_align");
    @(posedge clk); #1;
    issue_cmd(2'd0, 32'd50, 1'b0, 1'b1, lat);
    chk("cfg_irq_latency", 32'(lat), 32'd4);
    @(negedge clk);
    chk("cfg_irq_pending", 32'(irq), 32'h1);
    chk("cfg_irq_ready_low", 32'(cmd_ready), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("cfg_irq_clear", {29'h0, avm_chipselect, avm_write_n, 1'b0}, 32'h4);
    chk("cfg_irq_clear_addr", 32'(avm_address), 32'h0);
    @(posedge clk); #1;

    // Random commands, fields scrambled while each sequence runs.
    for (int c = 0; c < 150; c++) begin
      repeat ($urandom_range(0, 4)) begin
        cmd_period = $urandom; cmd_op = 2'($urandom);
        @(posedge clk); #1;
      end
      issue_cmd(2'($urandom_range(0, 3)), 32'($urandom_range(2, 40)),
                1'($urandom), 1'($urandom), lat);
    end
    repeat (10) begin @(posedge clk); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
